// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W integer register file, one write port, two async read ports, x0 reads zero.
// Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle write data onto matching read ports.
`timescale 1ns/1ps
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // x0 has no storage; the array starts at index 1.
  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic              w_wr_en;

  assign w_wr_en = we && (waddr != {ADDR_W{1'b0}});

  // Register storage: async clear of x1..xN, write on rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Read port 1: x0 forced to zero, optional forwarding of the in-flight write.
  always_comb begin
    rdata1 = {DATA_W{1'b0}};
    if (raddr1 == {ADDR_W{1'b0}}) begin
      rdata1 = {DATA_W{1'b0}};
    end else begin
      rdata1 = r_regs[raddr1];
    end
`ifdef REGFILE_WR_BYPASS_EN
    if (w_wr_en && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = rdata1;
    end
`endif
  end

  // Read port 2: identical to port 1, fully independent.
  always_comb begin
    rdata2 = {DATA_W{1'b0}};
    if (raddr2 == {ADDR_W{1'b0}}) begin
      rdata2 = {DATA_W{1'b0}};
    end else begin
      rdata2 = r_regs[raddr2];
    end
`ifdef REGFILE_WR_BYPASS_EN
    if (w_wr_en && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = rdata2;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks;
  int failures;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{a1: 5'd10, a2: 5'd20, e1: 32'd100, e2: 32'd200};
    vecs[1] = '{a1: 5'd31, a2: 5'd31, e1: 32'd310, e2: 32'd310};
    vecs[2] = '{a1: 5'd0,  a2: 5'd5,  e1: 32'd0,   e2: 32'd50};
    vecs[3] = '{a1: 5'd7,  a2: 5'd0,  e1: 32'd70,  e2: 32'd0};
    vecs[4] = '{a1: 5'd1,  a2: 5'd31, e1: 32'd10,  e2: 32'd310};
    vecs[5] = '{a1: 5'd16, a2: 5'd15, e1: 32'd160, e2: 32'd150};

    rst_n = 1'b0;
    we = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    raddr1 = 5'd1;
    raddr2 = 5'd31;
    #1;
    chk("reset_r1", rdata1, 32'd0);
    chk("reset_r2", rdata2, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // x0 write is discarded
    wr(5'd0, 32'hDEADBEEF);
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    chk("x0_r1", rdata1, 32'd0);
    chk("x0_r2", rdata2, 32'd0);

    // Fill, with a 1-edge write-to-read latency check on each
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      wr(5'(i), 32'(i * 10));
      chk("fill_latency", rdata1, 32'(i * 10));
    end
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'd0;
      #1;
      chk("fill_p1", rdata1, 32'(i * 10));
      chk("fill_p1_x0", rdata2, 32'd0);
      raddr1 = 5'd0;
      raddr2 = 5'(i);
      #1;
      chk("fill_p2_x0", rdata1, 32'd0);
      chk("fill_p2", rdata2, 32'(i * 10));
    end

    for (int v = 0; v < 6; v++) begin
      raddr1 = vecs[v].a1;
      raddr2 = vecs[v].a2;
      #1;
      chk("vec_r1", rdata1, vecs[v].e1);
      chk("vec_r2", rdata2, vecs[v].e2);
    end

    // we=0 guard over several edges
    @(negedge clk);
    we = 1'b0;
    waddr = 5'd7;
    wdata = 32'hFFFFFFFF;
    raddr1 = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("we0_guard", rdata1, 32'd70);

    // Same-cycle write/read of x5
    @(negedge clk);
    we = 1'b1;
    waddr = 5'd5;
    wdata = 32'h1234;
    raddr1 = 5'd5;
    raddr2 = 5'd6;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("hazard_pre", rdata1, 32'h1234);
`else
    chk("hazard_pre", rdata1, 32'd50);
`endif
    chk("hazard_other", rdata2, 32'd60);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("hazard_post", rdata1, 32'h1234);

    // x0 is never forwarded
    @(negedge clk);
    we = 1'b1;
    waddr = 5'd0;
    wdata = 32'hDEADBEEF;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    chk("x0_fwd_r1", rdata1, 32'd0);
    chk("x0_fwd_r2", rdata2, 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;

    // Overwrite: last write wins
    wr(5'd6, 32'hAAAA_AAAA);
    wr(5'd6, 32'h5555_5555);
    raddr1 = 5'd6;
    #1;
    chk("overwrite", rdata1, 32'h5555_5555);

    // Async reset pulse of 3 ns with no clock edge
    @(posedge clk);
    #1;
    raddr1 = 5'd10;
    raddr2 = 5'd31;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_r1", rdata1, 32'd0);
    chk("rst_pulse_r2", rdata2, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(32 - i);
      #0.1;
      chk("rst_all_r1", rdata1, 32'd0);
      chk("rst_all_r2", rdata2, 32'd0);
    end

    // Write held during reset across an edge is ignored
    wr(5'd3, 32'd33);
    @(negedge clk);
    rst_n = 1'b0;
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'hFFFF;
    raddr1 = 5'd3;
    @(posedge clk);
    #2;
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("wr_in_reset", rdata1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
